// File: rtl/belt_warn_ctrl_if.sv
// Seat-belt warning bus: raw key/seat/belt inputs in, warning/chime/lamps out.
// Optional MUTE (macro BELT_CHIME_MUTE_EN). master = sensor/cluster side, slave = controller.
interface belt_warn_ctrl_if #(
  parameter int NUM_SEATS = 2
);
  logic                 K;
  logic [NUM_SEATS-1:0] P;
  logic [NUM_SEATS-1:0] S;
`ifdef BELT_CHIME_MUTE_EN
  logic                 MUTE;
`endif
  logic                 W;
  logic                 CHIME;
  logic [NUM_SEATS-1:0] LAMP;

  modport master (
    output K, P, S,
`ifdef BELT_CHIME_MUTE_EN
    output MUTE,
`endif
    input  W, CHIME, LAMP
  );

  modport slave (
    input  K, P, S,
`ifdef BELT_CHIME_MUTE_EN
    input  MUTE,
`endif
    output W, CHIME, LAMP
  );
endinterface

// File: rtl/belt_warn_ctrl.sv
// Multi-seat belt warning: debounced P/S, grace after key-on, chime with timeout, re-arm.
// Ports: CLK, RST_N (sync, active-low), bus (slave: K,P,S[,MUTE] in; W,CHIME,LAMP out).
// Optional feature macro: BELT_CHIME_MUTE_EN (MUTE forces WARN -> LAMP_ONLY).
module belt_warn_ctrl #(
  parameter int NUM_SEATS    = 2,
  parameter int DB_CYC       = 4,
  parameter int GRACE_CYC    = 16,
  parameter int CHIME_HALF   = 8,
  parameter int WARN_TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RST_N,
  belt_warn_ctrl_if.slave  bus
);

  localparam int MAXT = (GRACE_CYC > WARN_TIMEOUT) ? GRACE_CYC : WARN_TIMEOUT;
  localparam int TW   = $clog2(MAXT + 1);
  localparam int CW   = $clog2(DB_CYC + 1);
  localparam int PW   = (CHIME_HALF > 1) ? $clog2(CHIME_HALF) : 1;

  localparam logic [TW-1:0] G_LAST  = TW'(GRACE_CYC - 1);
  localparam logic [TW-1:0] W_LAST  = TW'(WARN_TIMEOUT - 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYC - 1);
  localparam logic [PW-1:0] PH_LAST = PW'(CHIME_HALF - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRACE     = 2'd1,
    WARN      = 2'd2,
    LAMP_ONLY = 2'd3
  } state_e;

  state_e                        state_q, state_d;
  logic [TW-1:0]                 tmr_q, tmr_d;
  logic [PW-1:0]                 ph_q, ph_d;
  logic                          chime_q, chime_d;
  logic [NUM_SEATS-1:0]          uref_q, uref_d;
  logic                          kr_q;
  logic [NUM_SEATS-1:0]          pd_q, pd_d;
  logic [NUM_SEATS-1:0]          sd_q, sd_d;
  logic [NUM_SEATS-1:0][CW-1:0]  pcnt_q, pcnt_d;
  logic [NUM_SEATS-1:0][CW-1:0]  scnt_q, scnt_d;

  logic [NUM_SEATS-1:0] u;
  logic                 any_u;
  logic                 mute;
  logic                 w_o;
  logic                 chime_o;
  logic [NUM_SEATS-1:0] lamp_o;

`ifdef BELT_CHIME_MUTE_EN
  assign mute = bus.MUTE;
`else
  assign mute = 1'b0;
`endif

  assign u     = pd_q & ~sd_q;
  assign any_u = |u;

  // Per-bit debounce: count cycles of disagreement, adopt raw on the DB_CYC-th
  always_comb begin
    pd_d   = pd_q;
    sd_d   = sd_q;
    pcnt_d = '0;
    scnt_d = '0;
    for (int i = 0; i < NUM_SEATS; i++) begin
      if (bus.P[i] != pd_q[i]) begin
        if (pcnt_q[i] == DB_LAST) pd_d[i] = bus.P[i];
        else pcnt_d[i] = pcnt_q[i] + CW'(1);
      end
      if (bus.S[i] != sd_q[i]) begin
        if (scnt_q[i] == DB_LAST) sd_d[i] = bus.S[i];
        else scnt_d[i] = scnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      ph_q    <= '0;
      chime_q <= 1'b0;
      uref_q  <= '0;
      kr_q    <= 1'b0;
      pd_q    <= '0;
      sd_q    <= '0;
      pcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ph_q    <= ph_d;
      chime_q <= chime_d;
      uref_q  <= uref_d;
      kr_q    <= bus.K;
      pd_q    <= pd_d;
      sd_q    <= sd_d;
      pcnt_q  <= pcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    ph_d    = ph_q;
    chime_d = chime_q;
    uref_d  = uref_q;
    unique case (state_q)
      IDLE: begin
        if (kr_q && any_u) begin
          state_d = GRACE;
          tmr_d   = '0;
        end
      end
      GRACE: begin
        if (!kr_q || !any_u) begin
          state_d = IDLE;
        end else if (tmr_q == G_LAST) begin
          state_d = WARN;
          tmr_d   = '0;
          ph_d    = '0;
          chime_d = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      WARN: begin
        if (ph_q == PH_LAST) begin
          ph_d    = '0;
          chime_d = ~chime_q;
        end else begin
          ph_d = ph_q + PW'(1);
        end
        // Exit wins over timeout/mute on the same edge
        if (!kr_q || !any_u) begin
          state_d = IDLE;
        end else if (tmr_q == W_LAST || mute) begin
          state_d = LAMP_ONLY;
          uref_d  = u;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      LAMP_ONLY: begin
        if (!kr_q || !any_u) begin
          state_d = IDLE;
        end else if (|(u & ~uref_q)) begin
          state_d = WARN;
          tmr_d   = '0;
          ph_d    = '0;
          chime_d = 1'b1;
        end else begin
          // Drop re-belted seats so a later unbelt re-arms
          uref_d = u & uref_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    w_o     = 1'b0;
    chime_o = 1'b0;
    lamp_o  = '0;
    unique case (state_q)
      WARN: begin
        w_o     = 1'b1;
        chime_o = chime_q;
        lamp_o  = u;
      end
      LAMP_ONLY: begin
        w_o    = 1'b1;
        lamp_o = u;
      end
      default: begin
        w_o     = 1'b0;
        chime_o = 1'b0;
        lamp_o  = '0;
      end
    endcase
  end

  assign bus.W     = w_o;
  assign bus.CHIME = chime_o;
  assign bus.LAMP  = lamp_o;

endmodule
